// File: rtl/term_writer_if.sv
// rtl/term_writer_if.sv - character input and character-buffer write signals of term_writer
interface term_writer_if;
   logic        in_valid;
   logic [7:0]  in_char;
   logic        in_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data;
   logic [4:0]  top_row;
   logic [11:0] cursor_idx;

   modport master (
      output in_valid, in_char,
      input  in_ready, mem_we, mem_addr, mem_data, top_row, cursor_idx
   );

   modport slave (
      input  in_valid, in_char,
      output in_ready, mem_we, mem_addr, mem_data, top_row, cursor_idx
   );
endinterface

// File: rtl/term_writer.sv
// rtl/term_writer.sv - writes a character stream into a scrolling terminal character buffer
module term_writer #(
   parameter int TERM_W = 70,
   parameter int TERM_H = 30
) (
   input logic          clk_25M,
   input logic          rst,
   term_writer_if.slave bus
);
   localparam logic [1:0]  INIT  = 2'd0;
   localparam logic [1:0]  IDLE  = 2'd1;
   localparam logic [1:0]  WRITE = 2'd2;
   localparam logic [1:0]  CLEAR = 2'd3;

   localparam logic [11:0] LAST_COL  = 12'(TERM_W - 1);
   localparam logic [11:0] ROW_STEP  = 12'(TERM_W);
   localparam logic [11:0] LAST_CELL = 12'(TERM_W * TERM_H - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(TERM_H - 1);
   localparam logic [7:0]  SPACE = 8'h20;
   localparam logic [7:0]  CH_BS = 8'h08;
   localparam logic [7:0]  CH_LF = 8'h0A;
   localparam logic [7:0]  CH_CR = 8'h0D;

   logic [1:0]  state;
   logic [11:0] col;
   logic [11:0] row_base;
   logic [11:0] clr_cnt;
   logic [4:0]  crow;
   logic [4:0]  phys;
   logic [4:0]  top_row;
   logic        wr_adv;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data;
   logic [11:0] cursor_idx;

   logic        accept;
   logic        printable;
   logic        newline;
   logic [4:0]  phys_nx;
   logic [4:0]  top_nx;
   logic [11:0] base_nx;

   // Physical row and its base address always advance together, so the
   // buffer address is a running sum rather than a row*width product.
   always_comb begin
      accept    = (state == IDLE) && bus.in_valid;
      printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
      newline   = (accept && bus.in_char == CH_LF) ||
                  (state == WRITE && wr_adv && col == LAST_COL);
      phys_nx   = (phys == LAST_ROW) ? 5'd0 : phys + 5'd1;
      base_nx   = (phys == LAST_ROW) ? 12'd0 : row_base + ROW_STEP;
      top_nx    = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
   end

   assign cursor_idx = row_base + col;

   always_ff @(posedge clk_25M or posedge rst) begin
      if (rst) begin
         state    <= INIT;
         col      <= '0;
         crow     <= '0;
         phys     <= '0;
         row_base <= '0;
         top_row  <= '0;
         clr_cnt  <= '0;
         wr_adv   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= SPACE;
      end else if (newline) begin
         col      <= '0;
         phys     <= phys_nx;
         row_base <= base_nx;
         if (crow == LAST_ROW) begin
            top_row  <= top_nx;
            state    <= CLEAR;
            mem_we   <= 1'b1;
            mem_addr <= base_nx;
            mem_data <= SPACE;
            clr_cnt  <= '0;
         end else begin
            crow   <= crow + 5'd1;
            state  <= IDLE;
            mem_we <= 1'b0;
         end
      end else begin
         case (state)
            INIT: begin
               // The first INIT cycle only raises the strobe; mem_addr is the fill counter.
               mem_data <= SPACE;
               if (!mem_we) begin
                  mem_we <= 1'b1;
               end else if (mem_addr == LAST_CELL) begin
                  mem_we <= 1'b0;
                  state  <= IDLE;
               end else begin
                  mem_addr <= mem_addr + 12'd1;
               end
            end
            IDLE: begin
               if (accept) begin
                  if (printable) begin
                     state    <= WRITE;
                     mem_we   <= 1'b1;
                     mem_addr <= cursor_idx;
                     mem_data <= bus.in_char;
                     wr_adv   <= 1'b1;
                  end else if (bus.in_char == CH_CR) begin
                     col <= '0;
                  end else if (bus.in_char == CH_BS && col != 12'd0) begin
                     col      <= col - 12'd1;
                     state    <= WRITE;
                     mem_we   <= 1'b1;
                     mem_addr <= cursor_idx - 12'd1;
                     mem_data <= SPACE;
                     wr_adv   <= 1'b0;
                  end
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               state  <= IDLE;
               if (wr_adv) begin
                  col <= col + 12'd1;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST_COL) begin
                  mem_we <= 1'b0;
                  state  <= IDLE;
               end else begin
                  clr_cnt  <= clr_cnt + 12'd1;
                  mem_addr <= mem_addr + 12'd1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_data   = mem_data;
   assign bus.top_row    = top_row;
   assign bus.cursor_idx = cursor_idx;
endmodule

// File: tb/tb_term_writer.sv
// tb/tb_term_writer.sv - bench for term_writer against a screen-level reference model
module tb_term_writer;
   localparam int W = 70;
   localparam int H = 30;
   localparam int CELLS = W * H;

   logic clk = 1'b0;
   logic rst = 1'b1;

   term_writer_if bus();

   term_writer #(.TERM_W(W), .TERM_H(H)) dut (
      .clk_25M(clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #20 clk = ~clk;

   int checks = 0;
   int passed = 0;
   logic [19:0] wq[$];
   logic [19:0] exp_q[$];
   int m_col = 0;
   int m_row = 0;
   int m_top = 0;
   int range_err = 0;
   int idle_we_err = 0;

   // Write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.mem_we) begin
         wq.push_back({bus.mem_addr, bus.mem_data});
         if (int'(bus.mem_addr) > CELLS - 1) range_err++;
         if (bus.in_ready) idle_we_err++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int m_idx();
      return ((m_top + m_row) % H) * W + m_col;
   endfunction

   task automatic m_newline();
      m_col = 0;
      if (m_row < H - 1) m_row++;
      else begin
         m_top = (m_top + 1) % H;
         for (int i = 0; i < W; i++)
            exp_q.push_back({12'(((m_top + m_row) % H) * W + i), 8'h20});
      end
   endtask

   task automatic m_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         exp_q.push_back({12'(m_idx()), c});
         if (m_col == W - 1) m_newline();
         else m_col++;
      end else if (c == 8'h0D) m_col = 0;
      else if (c == 8'h0A) m_newline();
      else if (c == 8'h08 && m_col > 0) begin
         m_col--;
         exp_q.push_back({12'(m_idx()), 8'h20});
      end
   endtask

   task automatic wait_ready(input int limit, output int busy, output logic to);
      busy = 0;
      to = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            to = 1'b0;
            break;
         end
         busy++;
      end
   endtask

   task automatic cmp_writes(input string tag);
      int bad = 0;
      check({tag, "_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         if (wq[i] !== exp_q[i]) bad++;
      check({tag, "_data"}, bad, 0);
      wq.delete();
      exp_q.delete();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_mem_we"}, bus.mem_we, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_data"}, bus.mem_data, 8'h20);
      check({tag, "_top_row"}, bus.top_row, 0);
      check({tag, "_cursor"}, bus.cursor_idx, 0);
   endtask

   task automatic init_phase(input string tag);
      logic to = 1'b1;
      logic prev_we = 1'b0;
      int bad = 0;
      wq.delete();
      for (int i = 0; i < CELLS + 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            to = 1'b0;
            break;
         end
         prev_we = bus.mem_we;
      end
      check({tag, "_timeout"}, to, 0);
      check({tag, "_ready_after_last"}, prev_we, 1);
      check({tag, "_count"}, wq.size(), CELLS);
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] !== {12'(i), 8'h20}) bad++;
      check({tag, "_data"}, bad, 0);
      wq.delete();
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      m_top = 0;
   endtask

   task automatic send_char(input logic [7:0] c, input string tag);
      int busy;
      logic to;
      wq.delete();
      exp_q.delete();
      m_char(c);
      bus.in_valid = 1'b1;
      bus.in_char = c;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_ready(200, busy, to);
      check({tag, "_timeout"}, to, 0);
      check({tag, "_busy"}, busy, exp_q.size());
      cmp_writes(tag);
      check({tag, "_cursor"}, bus.cursor_idx, m_idx());
      check({tag, "_top_row"}, bus.top_row, m_top);
   endtask

   function automatic logic [7:0] rand_char();
      int r = int'($urandom_range(0, 15));
      if (r < 10) return 8'($urandom_range(32, 126));
      if (r < 12) return 8'h0A;
      if (r == 12) return 8'h0D;
      if (r == 13) return 8'h08;
      if (r == 14) return 8'($urandom_range(0, 7));
      return 8'($urandom_range(128, 255));
   endfunction

   initial begin
      int busy;
      logic to;
      logic [3:0] rdy;

      bus.in_valid = 1'b0;
      bus.in_char = 8'h00;
      repeat (3) @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      init_phase("init");

      // 'A','B' with in_valid held high
      wq.delete();
      exp_q.delete();
      m_char(8'h41);
      m_char(8'h42);
      bus.in_valid = 1'b1;
      bus.in_char = 8'h41;
      rdy[3] = bus.in_ready;
      @(negedge clk);
      rdy[2] = bus.in_ready;
      bus.in_char = 8'h42;
      @(negedge clk);
      rdy[1] = bus.in_ready;
      @(negedge clk);
      rdy[0] = bus.in_ready;
      bus.in_valid = 1'b0;
      wait_ready(10, busy, to);
      check("ab_ready_seq", rdy, 4'b1010);
      check("ab_timeout", to, 0);
      cmp_writes("ab");
      check("ab_cursor", bus.cursor_idx, 2);

      send_char(8'h0D, "cr");
      for (int i = 0; i < W; i++) send_char(8'h78, "row_fill");
      check("row_fill_cursor70", bus.cursor_idx, 70);

      send_char(8'h51, "q");
      send_char(8'h08, "bs1");
      send_char(8'h08, "bs2");
      send_char(8'h01, "ignored_ctrl");
      send_char(8'h7F, "ignored_del");

      while (m_row < H - 1) send_char(8'h0A, "lf");
      send_char(8'h0A, "lf_scroll");

      // printable at the last cell of the bottom row: one write then a full clear
      send_char(8'h0D, "corner_cr");
      for (int i = 0; i < W; i++) send_char(8'h7A, "corner");

      for (int i = 0; i < 300; i++) send_char(rand_char(), "rand");

      // reset in the middle of a scroll clear
      while (m_row < H - 1) send_char(8'h0A, "lf_pre");
      bus.in_valid = 1'b1;
      bus.in_char = 8'h0A;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (35) @(negedge clk);
      check("clear_active", bus.mem_we, 1);
      rst = 1'b1;
      #1 check_reset("mid_clear_reset");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      init_phase("reinit");
      send_char(8'h41, "after_reinit");

      check("addr_range", range_err, 0);
      check("we_in_idle", idle_we_err, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/term_writer.md
TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 Parameter TERM_W, default 70, meaning characters per terminal row.
REQ-002 Parameter TERM_H, default 30, meaning rows per terminal screen.
REQ-003 clk_25M  input  1  pixel-domain clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer has a character on in_char.
REQ-006 in_char  input  8  ASCII character or control code.
REQ-007 in_ready  output  1  block can accept a character this cycle.
REQ-008 mem_we  output  1  write strobe to the character buffer; one word per asserted cycle.
REQ-009 mem_addr  output  12  character buffer index, in the range 0..TERM_W*TERM_H-1.
REQ-010 mem_data  output  8  character code to be written.
REQ-011 top_row  output  5  physical buffer row currently displayed as screen row 0, in the range 0..TERM_H-1.
REQ-012 cursor_idx  output  12  buffer index of the next write position.

Function
REQ-013 The block SHALL implement FSM states INIT, IDLE, WRITE and CLEAR; mem_addr, mem_data and mem_we SHALL all be registered.
REQ-014 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Cursor SHALL be held as col (0..TERM_W-1) and logical row crow (0..TERM_H-1); phys = (top_row+crow) mod TERM_H; cursor_idx = phys*TERM_W+col.
REQ-016 For a printable character (0x20..0x7E): move IDLE->WRITE, assert mem_we=1 for exactly one cycle with mem_addr=cursor_idx and mem_data=in_char, then advance col.
REQ-017 If col=TERM_W-1 when the printable character is written, the block SHALL perform a newline (REQ-019) instead of incrementing col.
REQ-018 For 0x0D (CR): col<=0; no write; remain in IDLE, with in_ready staying 1 on the next cycle.
REQ-019 For 0x0A (LF) or an auto-wrap: col<=0; if crow<TERM_H-1 then crow<=crow+1 and the FSM returns to IDLE; otherwise scroll (REQ-020).
REQ-020 Scroll: crow stays at TERM_H-1 and top_row<=(top_row+1) mod TERM_H; the FSM enters CLEAR and writes 0x20 to every cell of the new bottom physical row, ascending, one cell per cycle for TERM_W cycles, then returns to IDLE.
REQ-021 For 0x08 (BS) with col>0: col<=col-1 and a WRITE cycle stores 0x20 at the new cursor_idx; with col=0 the code SHALL have no effect.
REQ-022 All other codes SHALL be consumed and ignored, with no write and no cursor change.
REQ-023 A printable character at col=TERM_W-1, crow=TERM_H-1 SHALL produce one WRITE cycle followed directly by TERM_W CLEAR cycles, with in_ready=0 throughout.
REQ-024 mem_we SHALL be 0 in IDLE; mem_addr SHALL never exceed TERM_W*TERM_H-1; top_row wraps from TERM_H-1 to 0.
REQ-025 Address arithmetic SHALL be 12-bit; phys*TERM_W SHALL be produced by a registered row-base value updated on row change, with no combinational multiply on the mem_addr path.

Reset
REQ-026 While rst=1: in_ready=0, mem_we=0, mem_addr=0, mem_data=0x20, top_row=0, col=0, crow=0, cursor_idx=0, state=INIT.
REQ-027 After rst is released, INIT SHALL write 0x20 to addresses 0..TERM_W*TERM_H-1 in order, one per cycle (2100 cycles at the defaults), then enter IDLE.
REQ-028 Asserting rst in any state, including mid-CLEAR or mid-WRITE, SHALL abort the current operation and restart INIT; a character accepted before the reset is discarded.

Verification
REQ-029 Release reset -> 2100 consecutive writes of 0x20 at addresses 0..2099, followed by in_ready=1 on the next cycle.
REQ-030 Send 'A','B' with in_valid held high -> writes (0,0x41) then (1,0x42); in_ready toggles 1,0,1,0; cursor_idx=2.
REQ-031 Send 70 x 'x' from col 0, row 0 -> last write at address 69; cursor_idx=70; no CLEAR cycles.
REQ-032 Send 29 x LF, then LF again -> after the 30th LF: top_row=1 and 70 writes of 0x20 at addresses 0..69; cursor_idx=0 (phys row 0 is now the bottom row).
REQ-033 Send 'Q', BS, BS -> write (0,0x51), then write (0,0x20), then no write; cursor_idx=0.
REQ-034 Assert rst during the 35th CLEAR cycle -> outputs return to REQ-026 values, and after release INIT restarts at address 0.
